// File: rtl/fft_run_sequencer.sv
// Sequencer for one 8-point FFT pass: loads samples into the register file,
// starts the FFT engine, waits (bounded) for completion and strobes result capture.
module fft_run_sequencer #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_GPR_REGS    = 1,
    parameter int NUM_COEFFS_REGS = 30,
    parameter int NUM_FFT_REGS    = 32,
    parameter int TIMEOUT_CYCLES  = 255,
    localparam int ADDR_W = $clog2(NUM_GPR_REGS + NUM_COEFFS_REGS + NUM_FFT_REGS)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_real,
    input  logic [DATA_WIDTH-1:0] s_imag,
    input  logic                  h_valid,
    output logic                  h_ready,
    input  logic [ADDR_W-1:0]     h_addr,
    input  logic                  h_write_en,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_write_en,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  mm_fft_done,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic [2:0]            dbg_state
);

    localparam int FFT_POINTS = NUM_FFT_REGS / 4;
    localparam int RIN_BASE   = NUM_GPR_REGS + NUM_COEFFS_REGS;
    localparam int IIN_BASE   = RIN_BASE + FFT_POINTS;
    localparam int K_W        = (FFT_POINTS > 1) ? $clog2(FFT_POINTS) : 1;
    localparam int TMR_BITS   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMR_W      = (TMR_BITS > 8) ? TMR_BITS : 8;

    localparam logic [K_W-1:0]   LAST_K  = K_W'(FFT_POINTS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_RE = 3'd1,
        LOAD_IM = 3'd2,
        SETTLE  = 3'd3,
        RUN     = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    terr_q, terr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;

    logic                    run_first;
    logic                    timeout_hit;
    logic [ADDR_W-1:0]       rin_addr;
    logic [ADDR_W-1:0]       iin_addr;

    assign rin_addr  = ADDR_W'(RIN_BASE) + ADDR_W'(k_q);
    assign iin_addr  = ADDR_W'(IIN_BASE) + ADDR_W'(k_q);
    // Timer is cleared on RUN entry and bumped every RUN cycle without a completion,
    // so zero identifies the first RUN cycle.
    assign run_first = (timer_q == '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            timer_q <= '0;
            hold_q  <= '0;
            terr_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            terr_q  <= terr_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        terr_d      = terr_q;
        addr_d      = addr_q;
        timeout_hit = 1'b0;
        h_ready     = 1'b0;
        s_ready     = 1'b0;
        m_addr      = addr_q;
        m_write_en  = 1'b0;
        m_wdata     = hold_q;
        fft_start   = 1'b0;
        mm_fft_done = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Host owns the register-file port; a host access in the start cycle completes.
                h_ready    = 1'b1;
                m_addr     = h_addr;
                m_write_en = h_valid & h_write_en;
                m_wdata    = h_wdata;
                if (start) begin
                    state_d = LOAD_RE;
                    k_d     = '0;
                    terr_d  = 1'b0;
                end
            end
            LOAD_RE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    m_write_en = 1'b1;
                    m_addr     = rin_addr;
                    m_wdata    = s_real;
                    addr_d     = rin_addr;
                    hold_d     = s_imag;
                    state_d    = LOAD_IM;
                end
            end
            LOAD_IM: begin
                m_write_en = 1'b1;
                m_addr     = iin_addr;
                m_wdata    = hold_q;
                addr_d     = iin_addr;
                if (k_q == LAST_K) begin
                    state_d = SETTLE;
                end else begin
                    k_d     = k_q + K_W'(1);
                    state_d = LOAD_RE;
                end
            end
            SETTLE: begin
                timer_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // fft_done in the first cycle belongs to the previous run and is ignored.
                fft_start = run_first;
                if (fft_done && !run_first) begin
                    state_d = CAPTURE;
                end else if (timer_q == TMR_MAX) begin
                    timeout_hit = 1'b1;
                    terr_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CAPTURE: begin
                // No write here: the register file lets writes win over capture.
                mm_fft_done = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q | timeout_hit;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_run_sequencer.sv
// Bench for fft_run_sequencer: one default instance and one with a short timeout,
// register-file writes checked against an expected queue.
module tb_fft_run_sequencer;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int WW = AW + DW;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, sel;
    logic          s_valid, h_valid, h_write_en, fft_done;
    logic [DW-1:0] s_real, s_imag, h_wdata;
    logic [AW-1:0] h_addr;

    logic          a_busy, a_done, a_terr, a_s_ready, a_h_ready, a_we, a_mm, a_fs;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [2:0]    a_state;
    logic          b_busy, b_done, b_terr, b_s_ready, b_h_ready, b_we, b_mm, b_fs;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [2:0]    b_state;

    logic          o_busy, o_done, o_terr, o_s_ready, o_h_ready, o_we, o_mm, o_fs;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [2:0]    o_state;

    fft_run_sequencer dut (
        .clk(clk), .arst_n(arst_n), .start(start & ~sel), .busy(a_busy), .done(a_done),
        .timeout_err(a_terr), .s_valid(s_valid), .s_ready(a_s_ready), .s_real(s_real),
        .s_imag(s_imag), .h_valid(h_valid), .h_ready(a_h_ready), .h_addr(h_addr),
        .h_write_en(h_write_en), .h_wdata(h_wdata), .m_addr(a_addr), .m_write_en(a_we),
        .m_wdata(a_wdata), .mm_fft_done(a_mm), .fft_start(a_fs), .fft_done(fft_done),
        .dbg_state(a_state)
    );

    fft_run_sequencer #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .arst_n(arst_n), .start(start & sel), .busy(b_busy), .done(b_done),
        .timeout_err(b_terr), .s_valid(s_valid), .s_ready(b_s_ready), .s_real(s_real),
        .s_imag(s_imag), .h_valid(h_valid), .h_ready(b_h_ready), .h_addr(h_addr),
        .h_write_en(h_write_en), .h_wdata(h_wdata), .m_addr(b_addr), .m_write_en(b_we),
        .m_wdata(b_wdata), .mm_fft_done(b_mm), .fft_start(b_fs), .fft_done(fft_done),
        .dbg_state(b_state)
    );

    assign o_busy    = sel ? b_busy    : a_busy;
    assign o_done    = sel ? b_done    : a_done;
    assign o_terr    = sel ? b_terr    : a_terr;
    assign o_s_ready = sel ? b_s_ready : a_s_ready;
    assign o_h_ready = sel ? b_h_ready : a_h_ready;
    assign o_we      = sel ? b_we      : a_we;
    assign o_mm      = sel ? b_mm      : a_mm;
    assign o_fs      = sel ? b_fs      : a_fs;
    assign o_addr    = sel ? b_addr    : a_addr;
    assign o_wdata   = sel ? b_wdata   : a_wdata;
    assign o_state   = sel ? b_state   : a_state;

    logic [WW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_terr"}, 32'(o_terr), 0);
        check({tag, "_fft_start"}, 32'(o_fs), 0);
        check({tag, "_mm_fft_done"}, 32'(o_mm), 0);
        check({tag, "_s_ready"}, 32'(o_s_ready), 0);
        check({tag, "_m_write_en"}, 32'(o_we), 0);
        check({tag, "_h_ready"}, 32'(o_h_ready), 1);
        check({tag, "_state"}, 32'(o_state), 0);
    endtask

    // One pass: drives start, samples, host traffic and fft_done, scoreboards every
    // register-file write and checks event cycles relative to the start cycle (0).
    task automatic run_pass(input string name, input bit use_t, input bit throttle,
                            input int d1, input int d2, input bit host_start,
                            input bit host_busy, input bit restart, input int abort_c,
                            input int exp_fs, input int exp_cap, input int exp_done,
                            input int exp_terr, input bit exp_terr0);
        int si = 0;
        int fs_c = -1, cap_c = -1, done_c = -1, terr_c = -1, idle_c = -1;
        int n_fs = 0, n_cap = 0, n_done = 0;
        bit cap_we = 1'b0, h_acc = 1'b0, terr0 = 1'b0, aborted = 1'b0;
        logic [WW-1:0] w;
        sel = use_t;
        if (host_start) exp_q.push_back({AW'(0), DW'(16'h00A5)});
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back({AW'(31 + j), DW'(j + 1)});
            exp_q.push_back({AW'(39 + j), DW'(-(j + 1))});
        end
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (h_acc) begin h_valid = 1'b0; h_acc = 1'b0; end
            start = (c == 0) || (restart && c == 5);
            if (c == 0 && host_start) begin
                h_valid = 1'b1; h_write_en = 1'b1; h_addr = '0; h_wdata = 16'h00A5;
            end else if (host_busy && c == 3) begin
                h_valid = 1'b1; h_write_en = 1'b1; h_addr = '0; h_wdata = 16'h1234;
                exp_q.push_back({AW'(0), DW'(16'h1234)});
            end
            s_valid  = (si < 8) && !(throttle && c == 1 + 3 * si);
            s_real   = DW'(si + 1);
            s_imag   = DW'(-(si + 1));
            fft_done = (c == d1) || (c == d2);
            #1;
            if (o_we) begin
                check({name, "_write_expected"}, 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check({name, "_write"}, 32'({o_addr, o_wdata}), 32'(w));
                end
            end
            if (!throttle && c >= 1 && c <= 17) begin
                check({name, "_load_we"}, 32'(o_we), 32'(c <= 16));
                check({name, "_s_ready"}, 32'(o_s_ready), 32'(c % 2 == 1 && c <= 16));
            end
            if (c == 0) terr0 = o_terr;
            if (c == 1) check({name, "_busy_c1"}, 32'(o_busy), 1);
            if (o_busy && h_valid) check({name, "_h_stall"}, 32'(o_h_ready), 0);
            if (h_valid && o_h_ready) h_acc = 1'b1;
            if (s_valid && o_s_ready) si++;
            if (o_fs) begin n_fs++; if (fs_c < 0) fs_c = c; end
            if (o_mm) begin n_cap++; if (cap_c < 0) begin cap_c = c; cap_we = o_we; end end
            if (o_done) begin n_done++; if (done_c < 0) done_c = c; end
            if (c >= 1 && o_terr && terr_c < 0) terr_c = c;
            if (c == abort_c) begin
                #1 arst_n = 1'b0;
                #1 check_reset_outputs({name, "_async"});
                aborted = 1'b1;
                break;
            end
            if (c > 0 && !o_busy && done_c >= 0) begin idle_c = c; break; end
        end
        @(negedge clk);
        h_valid = 1'b0; start = 1'b0; s_valid = 1'b0; fft_done = 1'b0;
        if (aborted) begin
            exp_q.delete();
            arst_n = 1'b1;
        end else begin
            check({name, "_terr_before"}, 32'(terr0), 32'(exp_terr0));
            check({name, "_fft_start_cycle"}, 32'(fs_c), 32'(exp_fs));
            check({name, "_fft_start_pulses"}, 32'(n_fs), 1);
            check({name, "_capture_cycle"}, 32'(cap_c), 32'(exp_cap));
            check({name, "_capture_pulses"}, 32'(n_cap), 32'(exp_cap >= 0));
            if (exp_cap >= 0) check({name, "_capture_we"}, 32'(cap_we), 0);
            check({name, "_done_cycle"}, 32'(done_c), 32'(exp_done));
            check({name, "_done_pulses"}, 32'(n_done), 1);
            check({name, "_timeout_cycle"}, 32'(terr_c), 32'(exp_terr));
            check({name, "_idle_cycle"}, 32'(idle_c), 32'(exp_done + 1));
            check({name, "_queue_drained"}, 32'(exp_q.size()), 0);
        end
        exp_q.delete();
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; s_valid = 1'b0; h_valid = 1'b0; h_write_en = 1'b0;
        h_addr = '0; h_wdata = '0; s_real = '0; s_imag = '0; fft_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_a");
        sel = 1'b1; #1;
        check_reset_outputs("reset_b");
        sel = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // continuous stream, host write in start cycle, stale fft_done at cycle 18, restart ignored
        run_pass("cont", 1'b0, 1'b0, 18, 25, 1'b1, 1'b0, 1'b1, -1, 18, 26, 27, -1, 1'b0);
        // throttled stream with host write stalled during the pass
        run_pass("thr", 1'b0, 1'b1, 33, -1, 1'b0, 1'b1, 1'b0, -1, 26, 34, 35, -1, 1'b0);
        // short-timeout instance: no fft_done at all
        run_pass("tmo", 1'b1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, -1, 18, -1, 23, 22, 1'b0);
        // fft_done exactly when timer reaches the limit; start clears the sticky error
        run_pass("edge", 1'b1, 1'b0, 22, -1, 1'b0, 1'b0, 1'b0, -1, 18, 23, 24, -1, 1'b1);
        // asynchronous reset during LOAD_IM of sample 3, then a fresh pass
        run_pass("abort", 1'b0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 8, 0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        run_pass("fresh", 1'b0, 1'b0, 25, -1, 1'b0, 1'b0, 1'b0, -1, 18, 26, 27, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
